// File: rtl/dbg_access_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dbg_access_pkg                                             |
// | Purpose : Shared types and constants for the debug access master.    |
// |           Holds the FSM state encoding and the default debug        |
// |           address width.                                             |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package dbg_access_pkg;

  localparam int DBG_ADDR_WIDTH_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } dbg_state_e;

endpackage
`default_nettype wire

// File: rtl/dbg_access_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dbg_access_master                                          |
// | Purpose : Bridges single host commands onto a core debug port        |
// |           (req/gnt, then rvalid) and returns one response per        |
// |           command. REQ plus WAIT is bounded by TIMEOUT_CYCLES, after |
// |           which an error response is returned.                       |
// | Ports   : clk_i/rst_i        clock, synchronous active-high reset    |
// |           cmd_*              host command (valid/ready handshake)    |
// |           rsp_*              host response (valid/ready handshake)   |
// |           debug_*            core debug port request and response    |
// |           busy_o             high whenever the FSM is not idle       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dbg_access_master
  import dbg_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DBG_ADDR_WIDTH = DBG_ADDR_WIDTH_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [DBG_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      debug_req_o,
  output logic                      debug_we_o,
  output logic [DBG_ADDR_WIDTH-1:0] debug_addr_o,
  output logic [31:0]               debug_wdata_o,
  input  logic                      debug_gnt_i,
  input  logic                      debug_rvalid_i,
  input  logic [31:0]               debug_rdata_i,
  output logic                      busy_o
);

  localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  dbg_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_expired;

  // Greater-or-equal rather than equality: a grant on the threshold cycle
  // moves to WAIT with the counter already past the threshold, and the
  // wait must still be bounded on its very next cycle.
  assign w_expired = (r_cnt >= C_CNT_LAST);
  assign busy_o    = (r_state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      cmd_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      debug_req_o   <= 1'b0;
      debug_we_o    <= 1'b0;
      debug_addr_o  <= '0;
      debug_wdata_o <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Ready is registered so it rises one cycle after reset release.
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            debug_we_o    <= cmd_we_i;
            debug_addr_o  <= cmd_addr_i;
            debug_wdata_o <= cmd_wdata_i;
            r_cnt         <= '0;
            cmd_ready_o   <= 1'b0;
            debug_req_o   <= 1'b1;
            r_state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          // Completion is tested first so it wins over the timeout.
          if (debug_gnt_i) begin
            debug_req_o <= 1'b0;
            r_state     <= ST_WAIT;
          end else if (w_expired) begin
            debug_req_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (debug_rvalid_i) begin
            rsp_rdata_o <= debug_we_o ? 32'd0 : debug_rdata_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_expired) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_valid_o && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbg_access_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dbg_access_master                                       |
// | Purpose : Self-checking bench for dbg_access_master. Two instances:  |
// |           A with default timeout, B with TIMEOUT_CYCLES=4. They      |
// |           share all inputs except cmd_valid, which is steered by     |
// |           sel; observed outputs are muxed by sel. Expected responses |
// |           are queued at command acceptance and popped on rsp_valid.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_dbg_access_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        cmd_valid, cmd_we, rsp_ready, gnt, rvalid;
  logic [14:0] cmd_addr;
  logic [31:0] cmd_wdata, drdata;
  logic        cmd_valid_a, cmd_valid_b;

  logic        cmd_ready_a, rsp_valid_a, rsp_err_a, req_a, we_a, busy_a;
  logic [31:0] rdata_a, wdata_a;
  logic [14:0] addr_a;
  logic        cmd_ready_b, rsp_valid_b, rsp_err_b, req_b, we_b, busy_b;
  logic [31:0] rdata_b, wdata_b;
  logic [14:0] addr_b;

  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_req, o_we, o_busy;
  logic [31:0] o_rdata, o_wdata;
  logic [14:0] o_addr;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign cmd_valid_a = cmd_valid & ~sel;
  assign cmd_valid_b = cmd_valid & sel;

  always_comb begin
    o_cmd_ready = sel ? cmd_ready_b : cmd_ready_a;
    o_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    o_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
    o_req       = sel ? req_b       : req_a;
    o_we        = sel ? we_b        : we_a;
    o_busy      = sel ? busy_b      : busy_a;
    o_rdata     = sel ? rdata_b     : rdata_a;
    o_wdata     = sel ? wdata_b     : wdata_a;
    o_addr      = sel ? addr_b      : addr_a;
  end

  dbg_access_master #(.TIMEOUT_CYCLES(255), .DBG_ADDR_WIDTH(15)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_a), .cmd_ready_o(cmd_ready_a), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata_a),
    .rsp_err_o(rsp_err_a),
    .debug_req_o(req_a), .debug_we_o(we_a), .debug_addr_o(addr_a),
    .debug_wdata_o(wdata_a), .debug_gnt_i(gnt), .debug_rvalid_i(rvalid),
    .debug_rdata_i(drdata), .busy_o(busy_a)
  );

  dbg_access_master #(.TIMEOUT_CYCLES(4), .DBG_ADDR_WIDTH(15)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata_b),
    .rsp_err_o(rsp_err_b),
    .debug_req_o(req_b), .debug_we_o(we_b), .debug_addr_o(addr_b),
    .debug_wdata_o(wdata_b), .debug_gnt_i(gnt), .debug_rvalid_i(rvalid),
    .debug_rdata_i(drdata), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Offer a command for one cycle; the scoreboard entry is pushed here.
  task automatic send(input logic we, input logic [14:0] addr, input logic [31:0] wd,
                      input exp_t e);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
    exp_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, compare with the scoreboard, then
  // complete the handshake and check the return to idle.
  task automatic expect_rsp(input string tag, input int max_cyc);
    exp_t e;
    int   n = 0;
    while (!o_rsp_valid && n < max_cyc) begin tick(); n++; end
    check({tag, "_rsp_seen"}, o_rsp_valid, 1'b1);
    if (!o_rsp_valid) return;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_rdata"}, o_rdata, e.rdata);
    check({tag, "_err"}, o_rsp_err, e.err);
    check({tag, "_ready_in_resp"}, o_cmd_ready, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, o_rsp_valid, 1'b0);
    check({tag, "_idle_ready"}, o_cmd_ready, 1'b1);
    check({tag, "_idle_busy"}, o_busy, 1'b0);
  endtask

  // Transaction on B (TIMEOUT_CYCLES=4) with planned gnt/rvalid delays.
  // Relative cycle 0 is the first REQ cycle; the completion wins on the
  // threshold cycle, so errors follow from the delays alone.
  task automatic run_b(input int gd, input int rd, input logic we, input logic [31:0] data);
    exp_t e;
    int   k = 0;
    e.err   = (gd >= 4) || (rd >= 1 && gd + rd >= 3);
    e.rdata = (e.err || we) ? 32'd0 : data;
    send(we, 15'(gd * 16 + rd), 32'hA5A5_0000, e);
    while (!o_rsp_valid && k < 20) begin
      gnt    = (k == gd);
      rvalid = (k == gd + 1 + rd);
      drdata = data;
      tick();
      k++;
    end
    gnt = 1'b0; rvalid = 1'b0;
    expect_rsp($sformatf("rand_g%0d_r%0d", gd, rd), 2);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; gnt = 1'b0; rvalid = 1'b0; drdata = '0;

    // Reset state
    repeat (3) tick();
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_req", o_req, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rdata_err", {o_rdata, o_rsp_err}, 33'd0);
    check("rst_latched", {o_we, o_addr, o_wdata}, 48'd0);
    rst = 1'b0;
    tick();
    check("rst_release_ready", o_cmd_ready, 1'b1);

    // Minimum-latency read
    e = '{rdata: 32'hDEADBEEF, err: 1'b0};
    send(1'b0, 15'h0100, 32'h0, e);
    check("rd_req", o_req, 1'b1);
    check("rd_addr_we", {o_addr, o_we}, {15'h0100, 1'b0});
    check("rd_busy", o_busy, 1'b1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("rd_req_drop", o_req, 1'b0);
    rvalid = 1'b1; drdata = 32'hDEADBEEF;
    tick();
    rvalid = 1'b0;
    check("rd_latency3", o_rsp_valid, 1'b1);
    expect_rsp("rd_min", 0);

    // Write with grant delayed 5 cycles: request held for 6 cycles
    e = '{rdata: 32'd0, err: 1'b0};
    send(1'b1, 15'h2000, 32'h12345678, e);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("wr_req_c%0d", i), o_req, 1'b1);
      check($sformatf("wr_stable_c%0d", i), {o_we, o_addr, o_wdata},
            {1'b1, 15'h2000, 32'h12345678});
      gnt = (i == 5);
      tick();
    end
    gnt = 1'b0;
    check("wr_req_drop", o_req, 1'b0);
    rvalid = 1'b1; drdata = 32'hFFFF_FFFF;
    tick();
    rvalid = 1'b0;
    expect_rsp("wr_gnt5", 3);

    // TIMEOUT_CYCLES=4, grant never comes
    sel = 1'b1;
    e = '{rdata: 32'd0, err: 1'b1};
    send(1'b0, 15'h0033, 32'h0, e);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_c%0d", i), o_req, 1'b1);
      tick();
    end
    check("to_req_drop", o_req, 1'b0);
    check("to_rsp_now", o_rsp_valid, 1'b1);
    expect_rsp("to_gnt", 0);

    // TIMEOUT_CYCLES=4, rvalid exactly on the threshold cycle
    e = '{rdata: 32'hCAFEF00D, err: 1'b0};
    send(1'b0, 15'h0044, 32'h0, e);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tick();
    tick();
    rvalid = 1'b1; drdata = 32'hCAFEF00D;
    tick();
    rvalid = 1'b0;
    expect_rsp("thr_rvalid", 0);

    // Random delay mix on B around the threshold
    for (int t = 0; t < 8; t++)
      run_b(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)), $urandom);
    run_b(3, 0, 1'b0, 32'h0BAD_F00D);
    run_b(3, 1, 1'b0, 32'h0BAD_F00D);

    // Response back-pressure for 10 cycles with a competing command
    sel = 1'b0;
    e = '{rdata: 32'h1357_9BDF, err: 1'b0};
    send(1'b0, 15'h0200, 32'h0, e);
    gnt = 1'b1; tick(); gnt = 1'b0;
    rvalid = 1'b1; drdata = 32'h1357_9BDF; tick(); rvalid = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 15'h0042; cmd_wdata = 32'h55;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold_c%0d", i), {o_rsp_valid, o_rsp_err, o_rdata, o_cmd_ready},
            {1'b1, 1'b0, 32'h1357_9BDF, 1'b0});
      tick();
    end
    check("bp_no_req", o_req, 1'b0);
    e = exp_q.pop_front();
    check("bp_sb_rdata", o_rdata, e.rdata);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle", {o_rsp_valid, o_cmd_ready, o_busy}, 3'b010);
    exp_q.push_back('{rdata: 32'd0, err: 1'b0});
    tick();
    cmd_valid = 1'b0;
    check("bp_next_accept", {o_busy, o_req, o_we, o_addr}, {3'b111, 15'h0042});
    gnt = 1'b1; tick(); gnt = 1'b0;
    rvalid = 1'b1; drdata = 32'h7777_7777; tick(); rvalid = 1'b0;
    expect_rsp("bp_next", 1);

    // Reset pulsed in WAIT abandons the transaction
    send(1'b0, 15'h0300, 32'h0, '{rdata: 32'd0, err: 1'b0});
    void'(exp_q.pop_back());
    gnt = 1'b1; tick(); gnt = 1'b0;
    check("rw_in_wait", {o_busy, o_req}, 2'b10);
    rst = 1'b1;
    tick();
    check("rw_rst_outputs", {o_rsp_valid, o_req, o_busy}, 3'b000);
    rst = 1'b0;
    tick();
    check("rw_release_ready", o_cmd_ready, 1'b1);
    rvalid = 1'b1; drdata = 32'h9999_9999;
    tick();
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rw_stray_c%0d", i), {o_rsp_valid, o_busy, o_rdata}, 34'd0);
      tick();
    end
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
